// File: rtl/frame_mode_sequencer_pkg.sv
// Shared definitions for the frame mode sequencer: display modes, FSM states
// and mode classification helpers.
package frame_mode_sequencer_pkg;

  localparam logic [3:0] MODE_COLOR   = 4'd1;
  localparam logic [3:0] MODE_GRAY    = 4'd2;
  localparam logic [3:0] MODE_HIST    = 4'd3;
  localparam logic [3:0] MODE_THRESH  = 4'd4;
  localparam logic [3:0] MODE_CUMHIST = 4'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    CLEAR = 2'd2,
    SKIP  = 2'd3
  } state_t;

  function automatic logic is_hist_mode(input logic [3:0] mode);
    return (mode == MODE_HIST) || (mode == MODE_CUMHIST);
  endfunction

  function automatic logic is_valid_mode(input logic [3:0] mode);
    return (mode >= MODE_COLOR) && (mode <= MODE_CUMHIST);
  endfunction

endpackage

// File: rtl/frame_mode_sequencer_fval_edge_detect.sv
// Registers frame-valid and reports its rising and falling edges; the reset
// value of the register is configurable.
module fval_edge_detect #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic q;

  always_ff @(posedge clk) begin
    if (rst) q <= RST_VAL;
    else     q <= d;
  end

  assign rise = d & ~q;
  assign fall = ~d & q;

endmodule

// File: rtl/frame_mode_sequencer.sv
// Frame-level controller: latches display mode between frames, gates histogram
// accumulation, ping-pongs the histogram bank and sweeps a clear over it.
module frame_mode_sequencer
  import frame_mode_sequencer_pkg::*;
#(
  parameter int BIN_BITS = 8,
  parameter int FCNT_W   = 16
) (
  input  logic                CCD_PIXCLK,
  input  logic                iRst,
  input  logic                iFval,
  input  logic                iCCD_DVAL,
  input  logic [3:0]          iDisplaySelect,
  output logic [3:0]          oMode,
  output logic                oModeChange,
  output logic                oHistAccEn,
  output logic                oWrBank,
  output logic [BIN_BITS-1:0] oClrAddr,
  output logic                oClrWe,
  output logic                oFrameDone,
  output logic [FCNT_W-1:0]   oFrameCount,
  output logic                oOverrun,
  output logic                oBusy
);

  state_t state, state_nxt;
  logic   rise, fall;
  logic   hist_mode;
  logic   clr_last;
  logic   skip_pend;

  // Reset high so a reset released mid-frame does not look like a frame start.
  fval_edge_detect #(
    .RST_VAL(1'b1)
  ) u_fval_edge (
    .clk  (CCD_PIXCLK),
    .rst  (iRst),
    .d    (iFval),
    .rise (rise),
    .fall (fall)
  );

  assign hist_mode = is_hist_mode(oMode);
  assign clr_last  = (oClrAddr == '1);
  assign oBusy     = (state != IDLE);

  always_comb begin
    state_nxt  = state;
    oHistAccEn = 1'b0;
    oClrWe     = 1'b0;
    case (state)
      IDLE: begin
        if (rise) state_nxt = FRAME;
      end
      FRAME: begin
        oHistAccEn = iCCD_DVAL & iFval & hist_mode;
        if (fall) state_nxt = hist_mode ? CLEAR : IDLE;
      end
      CLEAR: begin
        oClrWe = 1'b1;
        if (clr_last) begin
          if (skip_pend) state_nxt = SKIP;
          else if (rise) state_nxt = FRAME;
          else           state_nxt = IDLE;
        end
      end
      SKIP: begin
        if (fall) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CCD_PIXCLK) begin
    if (iRst) begin
      state       <= IDLE;
      oMode       <= MODE_COLOR;
      oModeChange <= 1'b0;
      oWrBank     <= 1'b0;
      oClrAddr    <= '0;
      oFrameDone  <= 1'b0;
      oFrameCount <= '0;
      oOverrun    <= 1'b0;
      skip_pend   <= 1'b0;
    end else begin
      state       <= state_nxt;
      oModeChange <= 1'b0;
      oFrameDone  <= 1'b0;

      // A rise commits the frame to the mode already applied.
      if (state == IDLE && !rise && is_valid_mode(iDisplaySelect) &&
          iDisplaySelect != oMode) begin
        oMode       <= iDisplaySelect;
        oModeChange <= 1'b1;
      end

      if (state == FRAME && fall) begin
        oFrameDone  <= 1'b1;
        oFrameCount <= oFrameCount + 1'b1;
        oWrBank     <= ~oWrBank;
      end

      // Address wraps back to zero naturally after the last bin.
      if (state == CLEAR) begin
        oClrAddr <= oClrAddr + 1'b1;
        if (clr_last) begin
          skip_pend <= 1'b0;
        end else if (rise) begin
          oOverrun  <= 1'b1;
          skip_pend <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_mode_sequencer.sv
// Directed self-checking bench for frame_mode_sequencer.
module tb_frame_mode_sequencer;

  logic        clk = 1'b0;
  logic        iRst;
  logic        iFval;
  logic        iCCD_DVAL;
  logic [3:0]  iDisplaySelect;
  logic [3:0]  oMode;
  logic        oModeChange;
  logic        oHistAccEn;
  logic        oWrBank;
  logic [7:0]  oClrAddr;
  logic        oClrWe;
  logic        oFrameDone;
  logic [15:0] oFrameCount;
  logic        oOverrun;
  logic        oBusy;

  int n_vec = 0;
  int n_err = 0;

  int         n_done, n_mc, n_clr, n_busy, addr_err, mode_err, acc_err;
  logic [7:0] exp_addr;
  logic [3:0] hold_mode;

  always #5 clk = ~clk;

  frame_mode_sequencer #(
    .BIN_BITS(8),
    .FCNT_W  (16)
  ) dut (
    .CCD_PIXCLK     (clk),
    .iRst           (iRst),
    .iFval          (iFval),
    .iCCD_DVAL      (iCCD_DVAL),
    .iDisplaySelect (iDisplaySelect),
    .oMode          (oMode),
    .oModeChange    (oModeChange),
    .oHistAccEn     (oHistAccEn),
    .oWrBank        (oWrBank),
    .oClrAddr       (oClrAddr),
    .oClrWe         (oClrWe),
    .oFrameDone     (oFrameDone),
    .oFrameCount    (oFrameCount),
    .oOverrun       (oOverrun),
    .oBusy          (oBusy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr_cnt();
    n_done = 0; n_mc = 0; n_clr = 0; n_busy = 0;
    addr_err = 0; mode_err = 0; acc_err = 0;
  endtask

  // One pixel cycle: drive at the falling edge, observe 1 ns later.
  task automatic cyc(input logic fv, input logic dv);
    @(negedge clk);
    iFval = fv;
    iCCD_DVAL = dv;
    #1;
    if (oFrameDone === 1'b1) n_done++;
    if (oModeChange === 1'b1) n_mc++;
    if (oBusy === 1'b1) n_busy++;
    if (oClrWe === 1'b1) begin
      n_clr++;
      if (oClrAddr !== exp_addr) addr_err++;
      exp_addr = exp_addr + 8'd1;
    end
    if (oBusy === 1'b1 && oMode !== hold_mode) mode_err++;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) cyc(1'b0, 1'b0);
  endtask

  // Lines of 20 cycles: 4 blank then 16 valid pixels; ends with the fall cycle.
  task automatic run_frame(input int lines, input logic exp_hist, input logic [3:0] mid_sel);
    logic dv;
    for (int l = 0; l < lines; l++) begin
      for (int p = 0; p < 20; p++) begin
        if (l == lines / 2 && p == 0) iDisplaySelect = mid_sel;
        dv = (p >= 4);
        cyc(1'b1, dv);
        if (oHistAccEn !== (exp_hist & dv)) acc_err++;
      end
    end
    cyc(1'b0, 1'b0);
    if (oHistAccEn !== 1'b0) acc_err++;
  endtask

  initial begin
    iRst = 1'b1; iFval = 1'b0; iCCD_DVAL = 1'b0; iDisplaySelect = 4'd2;
    exp_addr = 8'd0; hold_mode = 4'd1;
    clr_cnt();

    // Reset values
    repeat (3) cyc(1'b0, 1'b0);
    check("rst_mode", oMode, 1);
    check("rst_modechg", oModeChange, 0);
    check("rst_accen", oHistAccEn, 0);
    check("rst_wrbank", oWrBank, 0);
    check("rst_clraddr", oClrAddr, 0);
    check("rst_clrwe", oClrWe, 0);
    check("rst_done", oFrameDone, 0);
    check("rst_count", oFrameCount, 0);
    check("rst_overrun", oOverrun, 0);
    check("rst_busy", oBusy, 0);
    iRst = 1'b0;
    clr_cnt();
    idle_cycles(4);
    check("t1_mode", oMode, 2);
    check("t1_pulses", n_mc, 1);

    // Colour frame: no accumulation, no clear
    iDisplaySelect = 4'd1;
    idle_cycles(2);
    hold_mode = 4'd1; clr_cnt();
    run_frame(4, 1'b0, 4'd1);
    idle_cycles(300);
    check("t2_accen", acc_err, 0);
    check("t2_mode", mode_err, 0);
    check("t2_done", n_done, 1);
    check("t2_clr", n_clr, 0);
    check("t2_count", oFrameCount, 1);
    check("t2_wrbank", oWrBank, 1);
    check("t2_busy", oBusy, 0);

    // Histogram frame followed by a full 256-bin clear
    iDisplaySelect = 4'd3;
    idle_cycles(2);
    hold_mode = 4'd3; clr_cnt();
    run_frame(4, 1'b1, 4'd3);
    idle_cycles(300);
    check("t3_accen", acc_err, 0);
    check("t3_done", n_done, 1);
    check("t3_clr", n_clr, 256);
    check("t3_addr", addr_err, 0);
    check("t3_count", oFrameCount, 2);
    check("t3_wrbank", oWrBank, 0);
    check("t3_busy", oBusy, 0);
    check("t3_overrun", oOverrun, 0);

    // Rise on the last clear address goes straight to FRAME without overrun
    clr_cnt();
    run_frame(4, 1'b1, 4'd3);
    idle_cycles(255);
    run_frame(4, 1'b1, 4'd3);
    idle_cycles(300);
    check("t3b_overrun", oOverrun, 0);
    check("t3b_done", n_done, 2);
    check("t3b_clr", n_clr, 512);
    check("t3b_addr", addr_err, 0);
    check("t3b_accen", acc_err, 0);
    check("t3b_count", oFrameCount, 4);
    check("t3b_wrbank", oWrBank, 0);

    // Cumulative histogram with an early frame: overrun and skipped frame
    iDisplaySelect = 4'd5;
    idle_cycles(2);
    hold_mode = 4'd5; clr_cnt();
    run_frame(4, 1'b1, 4'd5);
    idle_cycles(100);
    check("t4_no_overrun_yet", oOverrun, 0);
    run_frame(10, 1'b0, 4'd5);
    idle_cycles(300);
    check("t4_overrun", oOverrun, 1);
    check("t4_clr", n_clr, 256);
    check("t4_addr", addr_err, 0);
    check("t4_done", n_done, 1);
    check("t4_accen", acc_err, 0);
    check("t4_count", oFrameCount, 5);
    check("t4_wrbank", oWrBank, 1);
    check("t4_busy", oBusy, 0);

    // Mode request mid-frame is deferred until after the clear; 9 is ignored
    iDisplaySelect = 4'd3;
    idle_cycles(2);
    hold_mode = 4'd3; clr_cnt();
    run_frame(4, 1'b1, 4'd4);
    idle_cycles(300);
    check("t5_mode_hold", mode_err, 0);
    check("t5_accen", acc_err, 0);
    check("t5_clr", n_clr, 256);
    check("t5_mc", n_mc, 1);
    check("t5_mode", oMode, 4);
    check("t5_count", oFrameCount, 6);
    iDisplaySelect = 4'd9;
    clr_cnt();
    idle_cycles(10);
    check("t5_mode9", oMode, 4);
    check("t5_mc9", n_mc, 0);

    // Reset mid-frame with fval held high: no false frame start
    iDisplaySelect = 4'd4;
    hold_mode = 4'd4;
    idle_cycles(2);
    repeat (5) cyc(1'b1, 1'b0);
    check("t6_busy_pre", oBusy, 1);
    iRst = 1'b1;
    repeat (2) cyc(1'b1, 1'b0);
    iRst = 1'b0;
    clr_cnt();
    repeat (20) cyc(1'b1, 1'b1);
    idle_cycles(3);
    check("t6_busy", n_busy, 0);
    check("t6_done", n_done, 0);
    check("t6_count", oFrameCount, 0);
    check("t6_mode", oMode, 4);
    clr_cnt();
    run_frame(2, 1'b0, 4'd4);
    idle_cycles(3);
    check("t6_done2", n_done, 1);
    check("t6_count2", oFrameCount, 1);
    check("t6_wrbank2", oWrBank, 1);

    // Reset during the clear sweep at address 40
    iDisplaySelect = 4'd3;
    idle_cycles(2);
    hold_mode = 4'd3; clr_cnt(); exp_addr = 8'd0;
    run_frame(2, 1'b1, 4'd3);
    idle_cycles(41);
    check("t7_addr40", oClrAddr, 40);
    check("t7_we40", oClrWe, 1);
    iRst = 1'b1;
    cyc(1'b0, 1'b0);
    check("t7_we_rst", oClrWe, 0);
    check("t7_addr_rst", oClrAddr, 0);
    check("t7_busy_rst", oBusy, 0);
    check("t7_count_rst", oFrameCount, 0);
    check("t7_overrun_rst", oOverrun, 0);
    iRst = 1'b0;
    idle_cycles(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
